// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
//
// Purpose: FSM state type, next-PC action type, fetch buffer record, reset NOP
//          word and the word-alignment helper used by fetch_unit and fetch_next_pc.
// Ports:   none (package).
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_TRAP
  } fetch_state_e;

  // What the next-PC selector decided for this cycle while running.
  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_REDIRECT,
    ACT_TRAP
  } fetch_act_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_buf_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next-PC priority select and misalignment check
//
// Purpose: decides, for a running cycle, whether the fetch front end redirects,
//          traps on a misaligned target, holds for a stall or advances.
//          Priority: redirect > stall > advance.
// Ports:
//   pc               in   32  current architectural PC
//   stall            in   1   decode not ready
//   redirect_valid   in   1   redirect request this cycle
//   redirect_target  in   32  redirect byte address
//   act              out  2   selected action (fetch_act_e)
//   next_pc          out  32  PC to load on the coming edge
//   pc_plus4         out  32  pc + 4, wrapping modulo 2^32
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output fetch_act_e  act,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    act     = ACT_ADVANCE;
    next_pc = pc_plus4;
    if (redirect_valid) begin
      if (is_misaligned(redirect_target)) begin
        // A bad target freezes fetch; the PC is left where it was.
        act     = ACT_TRAP;
        next_pc = pc;
      end else begin
        act     = ACT_REDIRECT;
        next_pc = redirect_target;
      end
    end else if (stall) begin
      act     = ACT_HOLD;
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end with fetch buffer, redirect and trap
//
// Purpose: holds the PC, presents it to instruction memory, and registers the
//          returned word with its PC and PC+4 for decode. Handles stall,
//          redirect (one bubble) and a sticky trap on misaligned redirect.
// Optional feature: define FETCH_PERF_EN to add saturating perf counters.
// Ports:
//   clk              in   1   clock, rising edge
//   rst              in   1   synchronous active-high reset
//   stall            in   1   hold PC and fetch buffer
//   redirect_valid   in   1   take redirect_target as next PC
//   redirect_target  in   32  branch/jump target
//   imem_pc          out  32  current PC to instruction memory
//   imem_instr       in   32  word returned combinationally by imem
//   if_valid         out  1   fetch buffer holds a real instruction
//   if_pc            out  32  PC of buffered instruction
//   if_pc_plus4      out  32  if_pc + 4
//   if_instr         out  32  buffered instruction word
//   trap             out  1   misaligned redirect seen, fetch frozen
//   trap_addr        out  32  offending redirect target
//   perf_fetched     out  32  advances taken (FETCH_PERF_EN only)
//   perf_bubbles     out  32  running cycles with stall or redirect (FETCH_PERF_EN only)
module fetch_unit #(
  parameter logic [31:0] BASE_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
`endif
  output logic        trap,
  output logic [31:0] trap_addr
);

  import fetch_pkg::fetch_state_e;
  import fetch_pkg::fetch_act_e;
  import fetch_pkg::fetch_buf_t;
  import fetch_pkg::S_BOOT;
  import fetch_pkg::S_RUN;
  import fetch_pkg::S_TRAP;
  import fetch_pkg::ACT_ADVANCE;
  import fetch_pkg::ACT_HOLD;
  import fetch_pkg::ACT_REDIRECT;
  import fetch_pkg::ACT_TRAP;

  fetch_state_e state;
  logic [31:0]  pc;
  fetch_buf_t   fbuf;
  fetch_act_e   act;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;

  fetch_next_pc u_next_pc (
    .pc              (pc),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .act             (act),
    .next_pc         (next_pc),
    .pc_plus4        (pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_BOOT;
      pc             <= BASE_PC;
      fbuf.valid     <= 1'b0;
      fbuf.pc        <= 32'd0;
      fbuf.pc_plus4  <= 32'd0;
      fbuf.instr     <= NOP_INSTR;
      trap           <= 1'b0;
      trap_addr      <= 32'd0;
    end else begin
      case (state)
        // Single settling cycle after reset: nothing captured, PC held.
        S_BOOT: state <= S_RUN;
        S_RUN: begin
          case (act)
            ACT_REDIRECT: begin
              // The word fetched at the old PC is squashed into a bubble.
              pc         <= next_pc;
              fbuf.valid <= 1'b0;
              fbuf.instr <= NOP_INSTR;
            end
            ACT_TRAP: begin
              state      <= S_TRAP;
              trap       <= 1'b1;
              trap_addr  <= redirect_target;
              fbuf.valid <= 1'b0;
              fbuf.instr <= NOP_INSTR;
            end
            ACT_HOLD: ;
            ACT_ADVANCE: begin
              pc            <= next_pc;
              fbuf.valid    <= 1'b1;
              fbuf.pc       <= pc;
              fbuf.pc_plus4 <= pc_plus4;
              fbuf.instr    <= imem_instr;
            end
            default: ;
          endcase
        end
        // Sticky until reset.
        S_TRAP: ;
        default: state <= S_TRAP;
      endcase
    end
  end

  assign imem_pc     = pc;
  assign if_valid    = fbuf.valid;
  assign if_pc       = fbuf.pc;
  assign if_pc_plus4 = fbuf.pc_plus4;
  assign if_instr    = fbuf.instr;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_bubbles <= 32'd0;
    end else if (state == S_RUN) begin
      if (act == ACT_ADVANCE) begin
        if (perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
      end else if (act != ACT_HOLD || stall) begin
        if (perf_bubbles != 32'hFFFF_FFFF) perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (vectors, corner sequences, random vs model)
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  // Main instance, BASE_PC = 0
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_pc, imem_instr, if_pc, if_pc_plus4, if_instr, trap_addr;
  logic        if_valid, trap;
  logic [31:0] perf_fetched, perf_bubbles;

  assign imem_instr = mem_word(imem_pc);

  fetch_unit #(.BASE_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
`endif
    .trap(trap), .trap_addr(trap_addr)
  );

  // Wrap instance, BASE_PC near the top of the address space
  logic        w_rst, w_stall, w_rv;
  logic [31:0] w_tgt;
  logic [31:0] w_imem_pc, w_imem_instr, w_if_pc, w_if_pc_plus4, w_if_instr, w_trap_addr;
  logic        w_if_valid, w_trap;
  logic [31:0] w_perf_fetched, w_perf_bubbles;

  assign w_imem_instr = mem_word(w_imem_pc);

  fetch_unit #(.BASE_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(w_rst), .stall(w_stall), .redirect_valid(w_rv),
    .redirect_target(w_tgt), .imem_pc(w_imem_pc), .imem_instr(w_imem_instr),
    .if_valid(w_if_valid), .if_pc(w_if_pc), .if_pc_plus4(w_if_pc_plus4), .if_instr(w_if_instr),
`ifdef FETCH_PERF_EN
    .perf_fetched(w_perf_fetched), .perf_bubbles(w_perf_bubbles),
`endif
    .trap(w_trap), .trap_addr(w_trap_addr)
  );

`ifndef FETCH_PERF_EN
  assign perf_fetched   = 32'd0;
  assign perf_bubbles   = 32'd0;
  assign w_perf_fetched = 32'd0;
  assign w_perf_bubbles = 32'd0;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Directed vectors: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        rst, stall, rv;
    logic [31:0] tgt;
    logic [31:0] e_imem;
    logic        e_valid;
    logic [31:0] e_ifpc, e_p4, e_instr;
    logic        e_trap;
    logic [31:0] e_taddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic rv, input logic [31:0] tgt,
                     input logic [31:0] e_imem, input logic e_valid, input logic [31:0] e_ifpc,
                     input logic [31:0] e_p4, input logic [31:0] e_instr, input logic e_trap,
                     input logic [31:0] e_taddr);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.tgt = tgt; v.e_imem = e_imem; v.e_valid = e_valid;
    v.e_ifpc = e_ifpc; v.e_p4 = e_p4; v.e_instr = e_instr; v.e_trap = e_trap; v.e_taddr = e_taddr;
    vecs.push_back(v);
  endtask

  // Behavioural model: spec rules stated directly on plain variables.
  bit          m_boot, m_trapped;
  logic [31:0] m_pc, m_ifpc, m_p4, m_instr, m_taddr;
  bit          m_valid;
  longint      m_fetched, m_bubbles;

  task automatic model_edge(input bit r, input bit s, input bit rv, input logic [31:0] tgt);
    if (r) begin
      m_boot = 1; m_trapped = 0; m_pc = 32'd0; m_valid = 0; m_ifpc = 0; m_p4 = 0;
      m_instr = NOP; m_taddr = 0; m_fetched = 0; m_bubbles = 0;
    end else if (m_trapped) begin
    end else if (m_boot) begin
      m_boot = 0;
    end else if (rv || s) begin
      if (m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
      if (rv) begin
        m_valid = 0;
        m_instr = NOP;
        if (tgt % 4 != 0) begin
          m_trapped = 1;
          m_taddr   = tgt;
        end else begin
          m_pc = tgt;
        end
      end
    end else begin
      m_instr = mem_word(m_pc);
      m_ifpc  = m_pc;
      m_p4    = m_pc + 32'd4;
      m_valid = 1;
      m_pc    = m_pc + 32'd4;
      if (m_fetched < 64'hFFFF_FFFF) m_fetched++;
    end
  endtask

  initial begin
    rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
    w_rst = 1; w_stall = 0; w_rv = 0; w_tgt = 0;

    //   rst stall rv tgt          imem  vld ifpc   p4     instr             trap taddr
    add(1, 0, 0, 32'h0,   32'h0,   0, 32'h0,   32'h0,   NOP,                0, 32'h0);
    add(1, 0, 0, 32'h0,   32'h0,   0, 32'h0,   32'h0,   NOP,                0, 32'h0);
    add(0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   32'h0,   NOP,                0, 32'h0);
    add(0, 0, 0, 32'h0,   32'h4,   1, 32'h0,   32'h4,   mem_word(32'h0),    0, 32'h0);
    add(0, 0, 0, 32'h0,   32'h8,   1, 32'h4,   32'h8,   mem_word(32'h4),    0, 32'h0);
    add(0, 0, 0, 32'h0,   32'hC,   1, 32'h8,   32'hC,   mem_word(32'h8),    0, 32'h0);
    add(0, 0, 0, 32'h0,   32'h10,  1, 32'hC,   32'h10,  mem_word(32'hC),    0, 32'h0);
    add(0, 1, 1, 32'h100, 32'h100, 0, 32'hC,   32'h10,  NOP,                0, 32'h0);
    add(0, 0, 0, 32'h0,   32'h104, 1, 32'h100, 32'h104, mem_word(32'h100),  0, 32'h0);
    add(0, 0, 1, 32'h20,  32'h20,  0, 32'h100, 32'h104, NOP,                0, 32'h0);
    add(0, 0, 0, 32'h0,   32'h24,  1, 32'h20,  32'h24,  mem_word(32'h20),   0, 32'h0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 32'h0, 32'h24,  1, 32'h20,  32'h24,  mem_word(32'h20),   0, 32'h0);
    add(0, 0, 0, 32'h0,   32'h28,  1, 32'h24,  32'h28,  mem_word(32'h24),   0, 32'h0);
    add(0, 0, 1, 32'h102, 32'h28,  0, 32'h24,  32'h28,  NOP,                1, 32'h102);
    add(0, 0, 1, 32'h200, 32'h28,  0, 32'h24,  32'h28,  NOP,                1, 32'h102);
    add(0, 0, 0, 32'h0,   32'h28,  0, 32'h24,  32'h28,  NOP,                1, 32'h102);
    add(1, 0, 1, 32'h300, 32'h0,   0, 32'h0,   32'h0,   NOP,                0, 32'h0);
    add(0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   32'h0,   NOP,                0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; stall = vecs[i].stall;
      redirect_valid = vecs[i].rv; redirect_target = vecs[i].tgt;
      @(posedge clk); #1;
      check($sformatf("v%0d imem_pc", i), imem_pc, vecs[i].e_imem);
      check($sformatf("v%0d if_valid", i), if_valid, vecs[i].e_valid);
      check($sformatf("v%0d if_pc", i), if_pc, vecs[i].e_ifpc);
      check($sformatf("v%0d if_pc_plus4", i), if_pc_plus4, vecs[i].e_p4);
      check($sformatf("v%0d if_instr", i), if_instr, vecs[i].e_instr);
      check($sformatf("v%0d trap", i), trap, vecs[i].e_trap);
      check($sformatf("v%0d trap_addr", i), trap_addr, vecs[i].e_taddr);
    end

    // Wrap-around sequence on the second instance
    @(posedge clk); #1;
    w_rst = 0;
    @(posedge clk); #1;
    check("wrap boot if_valid", w_if_valid, 1'b0);
    check("wrap boot imem_pc", w_imem_pc, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("wrap if_pc 0", w_if_pc, 32'hFFFF_FFF8);
    check("wrap if_instr 0", w_if_instr, mem_word(32'hFFFF_FFF8));
    @(posedge clk); #1;
    check("wrap if_pc 1", w_if_pc, 32'hFFFF_FFFC);
    check("wrap if_pc_plus4 1", w_if_pc_plus4, 32'h0000_0000);
    @(posedge clk); #1;
    check("wrap if_pc 2", w_if_pc, 32'h0000_0000);
    check("wrap imem_pc 2", w_imem_pc, 32'h0000_0004);
    check("wrap if_valid 2", w_if_valid, 1'b1);
`ifdef FETCH_PERF_EN
    check("wrap perf_fetched", w_perf_fetched, 32'd3);
    check("wrap perf_bubbles", w_perf_bubbles, 32'd0);
`endif

    // Randomized run against the model
    rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
    model_edge(1, 0, 0, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] tgt;
      bit r, s, rv;
      r  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) tgt[31:4] = 28'hFFF_FFFF;
      rst = r; stall = s; redirect_valid = rv; redirect_target = tgt;
      model_edge(r, s, rv, tgt);
      @(posedge clk); #1;
      check($sformatf("rand c%0d state", c),
            {imem_pc, 3'b0, if_valid, if_pc, if_pc_plus4},
            {m_pc, 3'b0, m_valid, m_ifpc, m_p4});
      check($sformatf("rand c%0d instr/trap", c),
            {if_instr, 3'b0, trap, trap_addr},
            {m_instr, 3'b0, m_trapped, m_taddr});
`ifdef FETCH_PERF_EN
      check($sformatf("rand c%0d perf", c), {perf_fetched, perf_bubbles},
            {m_fetched[31:0], m_bubbles[31:0]});
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
